// File: rtl/lemming_pkg.sv
// Shared types for the lemming colony scheduler: state encoding, per-lemming
// context record and small state-classification helpers.
package lemming_pkg;

    typedef enum logic [2:0] {
        WALK_L = 3'd0,
        WALK_R = 3'd1,
        FALL_L = 3'd2,
        FALL_R = 3'd3,
        DIG_L  = 3'd4,
        DIG_R  = 3'd5,
        SPLAT  = 3'd6
    } lemming_state_t;

    // Direction of travel, carried implicitly by every non-SPLAT state
    localparam logic DIR_L = 1'b0;
    localparam logic DIR_R = 1'b1;

    // Fall counter width; large enough for any practical SPLAT_VISITS (< 32)
    localparam int FALL_CNT_W = 5;

    typedef struct packed {
        lemming_state_t              state;
        logic [FALL_CNT_W-1:0]       fall_cnt;
    } lemming_ctx_t;

    function automatic logic state_dir(input lemming_state_t s);
        return (s == WALK_R) || (s == FALL_R) || (s == DIG_R);
    endfunction

    function automatic logic is_dig(input lemming_state_t s);
        return (s == DIG_L) || (s == DIG_R);
    endfunction

    function automatic lemming_state_t walk_state(input logic dir);
        return (dir == DIR_R) ? WALK_R : WALK_L;
    endfunction

    function automatic lemming_state_t fall_state(input logic dir);
        return (dir == DIR_R) ? FALL_R : FALL_L;
    endfunction

    function automatic lemming_state_t dig_state(input logic dir);
        return (dir == DIR_R) ? DIG_R : DIG_L;
    endfunction

endpackage

// File: rtl/lemming_next_state.sv
// Shared combinational evaluator: given one lemming's context and its inputs
// for this visit, produce the context it holds after the next clock edge.
module lemming_next_state
    import lemming_pkg::*;
#(
    parameter int unsigned SPLAT_VISITS = 5
) (
    input  lemming_ctx_t ctx,
    input  logic         bump_left,
    input  logic         bump_right,
    input  logic         ground,
    input  logic         dig,
    input  logic         dig_allowed,
    output lemming_ctx_t ctx_next,
    output logic         deny
);

    localparam logic [FALL_CNT_W-1:0] SPLAT_CNT = FALL_CNT_W'(SPLAT_VISITS);

    logic dir;

    // Next-state rules for a single visit; falling off the ground has priority
    always_comb begin
        ctx_next = ctx;
        deny     = 1'b0;
        dir      = state_dir(ctx.state);
        case (ctx.state)
            WALK_L, WALK_R: begin
                if (!ground) begin
                    ctx_next.state    = fall_state(dir);
                    ctx_next.fall_cnt = '0;
                end else if (dig && dig_allowed) begin
                    ctx_next.state = dig_state(dir);
                end else begin
                    // A refused dig falls through to the plain walking rules
                    deny = dig;
                    if (dir == DIR_L && bump_left) begin
                        ctx_next.state = WALK_R;
                    end else if (dir == DIR_R && bump_right) begin
                        ctx_next.state = WALK_L;
                    end
                end
            end
            DIG_L, DIG_R: begin
                if (!ground) begin
                    ctx_next.state    = fall_state(dir);
                    ctx_next.fall_cnt = '0;
                end
            end
            FALL_L, FALL_R: begin
                if (!ground) begin
                    if (ctx.fall_cnt < SPLAT_CNT) begin
                        ctx_next.fall_cnt = ctx.fall_cnt + 1'b1;
                    end
                end else if (ctx.fall_cnt >= SPLAT_CNT) begin
                    ctx_next.state = SPLAT;
                end else begin
                    ctx_next.state    = walk_state(dir);
                    ctx_next.fall_cnt = '0;
                end
            end
            default: begin
                // SPLAT (and unused codes) hold until reset
            end
        endcase
    end

endmodule

// File: rtl/lemming_tdm_scheduler.sv
// Colony scheduler: a round-robin slot pointer time-shares one next-state
// evaluator across all stored lemming contexts and tracks digger/alive counts.
module lemming_tdm_scheduler
    import lemming_pkg::*;
#(
    parameter  int unsigned N_LEMMINGS   = 4,
    parameter  int unsigned SPLAT_VISITS = 5,
    parameter  int unsigned MAX_DIGGERS  = 1,
    localparam int          SLOT_W       = $clog2(N_LEMMINGS),
    localparam int          CNT_W        = $clog2(N_LEMMINGS + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  run,
    input  logic [N_LEMMINGS-1:0] bump_left,
    input  logic [N_LEMMINGS-1:0] bump_right,
    input  logic [N_LEMMINGS-1:0] ground,
    input  logic [N_LEMMINGS-1:0] dig,
    output logic [N_LEMMINGS-1:0] walk_left,
    output logic [N_LEMMINGS-1:0] walk_right,
    output logic [N_LEMMINGS-1:0] aaah,
    output logic [N_LEMMINGS-1:0] digging,
    output logic [N_LEMMINGS-1:0] dig_denied,
    output logic [SLOT_W-1:0]     cur_slot,
    output logic [CNT_W-1:0]      diggers,
    output logic [CNT_W-1:0]      alive
);

    lemming_ctx_t            ctx_q [N_LEMMINGS];
    lemming_ctx_t            ctx_d [N_LEMMINGS];
    logic [SLOT_W-1:0]       slot_q, slot_d;
    logic [CNT_W-1:0]        diggers_q, diggers_d;
    logic [CNT_W-1:0]        alive_q, alive_d;
    logic [N_LEMMINGS-1:0]   dig_denied_q, dig_denied_d;

    lemming_ctx_t            sel_ctx;
    lemming_ctx_t            eval_ctx;
    logic                    eval_deny;
    logic                    dig_allowed;

    assign sel_ctx     = ctx_q[slot_q];
    assign dig_allowed = (diggers_q < CNT_W'(MAX_DIGGERS));

    lemming_next_state #(
        .SPLAT_VISITS (SPLAT_VISITS)
    ) u_eval (
        .ctx         (sel_ctx),
        .bump_left   (bump_left[slot_q]),
        .bump_right  (bump_right[slot_q]),
        .ground      (ground[slot_q]),
        .dig         (dig[slot_q]),
        .dig_allowed (dig_allowed),
        .ctx_next    (eval_ctx),
        .deny        (eval_deny)
    );

    // Commit the evaluated context for the selected slot and adjust counters
    always_comb begin
        ctx_d        = ctx_q;
        slot_d       = slot_q;
        diggers_d    = diggers_q;
        alive_d      = alive_q;
        dig_denied_d = '0;
        if (run) begin
            ctx_d[slot_q] = eval_ctx;
            slot_d        = (slot_q == SLOT_W'(N_LEMMINGS - 1)) ? '0 : slot_q + 1'b1;
            if (is_dig(eval_ctx.state) && !is_dig(sel_ctx.state)) begin
                diggers_d = diggers_q + 1'b1;
            end else if (!is_dig(eval_ctx.state) && is_dig(sel_ctx.state)) begin
                diggers_d = diggers_q - 1'b1;
            end
            if (eval_ctx.state == SPLAT && sel_ctx.state != SPLAT) begin
                alive_d = alive_q - 1'b1;
            end
            dig_denied_d[slot_q] = eval_deny;
        end
    end

    // State registers with synchronous reset to an all-walking-left colony
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < N_LEMMINGS; k++) begin
                ctx_q[k] <= '{state: WALK_L, fall_cnt: '0};
            end
            slot_q       <= '0;
            diggers_q    <= '0;
            alive_q      <= CNT_W'(N_LEMMINGS);
            dig_denied_q <= '0;
        end else begin
            ctx_q        <= ctx_d;
            slot_q       <= slot_d;
            diggers_q    <= diggers_d;
            alive_q      <= alive_d;
            dig_denied_q <= dig_denied_d;
        end
    end

    // Moore output decode from the stored contexts
    always_comb begin
        walk_left  = '0;
        walk_right = '0;
        aaah       = '0;
        digging    = '0;
        for (int k = 0; k < N_LEMMINGS; k++) begin
            walk_left[k]  = (ctx_q[k].state == WALK_L) || (ctx_q[k].state == DIG_L);
            walk_right[k] = (ctx_q[k].state == WALK_R) || (ctx_q[k].state == DIG_R);
            aaah[k]       = (ctx_q[k].state == FALL_L) || (ctx_q[k].state == FALL_R);
            digging[k]    = is_dig(ctx_q[k].state);
        end
    end

    assign cur_slot   = slot_q;
    assign diggers    = diggers_q;
    assign alive      = alive_q;
    assign dig_denied = dig_denied_q;

endmodule
